// File: rtl/fir_fft_framer.sv
// fir_fft_framer: sits behind the 67-tap low-pass FIR and prepares FFT input.
// Keeps one of every DEC_FACTOR valid samples and clips it to OUT_W bits.
// Kept samples are packed into FRAME_LEN-sample frames held in two ping-pong banks.
// Finished frames stream out over valid/ready with start- and end-of-frame markers.
module fir_fft_framer #(
    parameter int DEC_FACTOR = 4,
    parameter int FRAME_LEN  = 64,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    input  logic signed [IN_W-1:0]  Y_IN,
    output logic signed [OUT_W-1:0] OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    OUT_SOF,
    output logic                    OUT_EOF,
    output logic                    SAT_FLAG,
    output logic [15:0]             DROP_CNT
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int DEC_W = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;

    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [DEC_W-1:0]       DEC_LAST = DEC_W'(DEC_FACTOR - 1);

    typedef enum logic {IDLE, STREAM} rd_state_t;

    rd_state_t state, state_next;

    // Both banks live in one array; the bank number is the top address bit.
    logic signed [OUT_W-1:0] mem [2*FRAME_LEN];

    logic [DEC_W-1:0] dec_cnt;
    logic             wr_bank, rd_bank;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [1:0]       full;

    logic                    keep, clip_hi, clip_lo, wr_free, do_write, do_drop, wr_last;
    logic                    beat, last_beat;
    logic signed [OUT_W-1:0] sat_sample;
    logic [1:0]              set_mask, rel_mask;

    // Decimation, saturation and bank hand-off decisions for the current cycle.
    always_comb begin
        keep       = IN_VALID && (dec_cnt == '0);
        clip_hi    = Y_IN > SAT_MAX;
        clip_lo    = Y_IN < SAT_MIN;
        sat_sample = clip_hi ? SAT_MAX[OUT_W-1:0] : (clip_lo ? SAT_MIN[OUT_W-1:0] : Y_IN[OUT_W-1:0]);
        beat       = (state == STREAM) && OUT_READY;
        last_beat  = beat && (rd_idx == LAST_IDX);
        // A bank emptied by the reader on this very edge may be refilled immediately.
        wr_free    = !full[wr_bank] || (last_beat && (rd_bank == wr_bank));
        do_write   = keep && wr_free;
        do_drop    = keep && !wr_free;
        wr_last    = do_write && (wr_idx == LAST_IDX);
        set_mask   = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
        rel_mask   = last_beat ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    end

    // Decimation phase counter; only valid input cycles advance it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dec_cnt <= '0;
        end else if (IN_VALID) begin
            dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DEC_W'(1);
        end
    end

    // Sample storage; contents are not cleared by reset because the full flags gate all reads.
    always_ff @(posedge CLK) begin
        if (!RST && do_write) begin
            mem[{wr_bank, wr_idx}] <= sat_sample;
        end
    end

    // Write pointer, sticky clip flag and saturating drop counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_idx   <= '0;
            wr_bank  <= 1'b0;
            SAT_FLAG <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            if (do_write) begin
                if (wr_last) begin
                    wr_idx  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (keep && (clip_hi || clip_lo)) begin
                SAT_FLAG <= 1'b1;
            end
            if (do_drop && (DROP_CNT != 16'hFFFF)) begin
                DROP_CNT <= DROP_CNT + 16'd1;
            end
        end
    end

    // Per-bank full flags: set by the writer on frame completion, cleared by the reader at EOF.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full <= '0;
        end else begin
            full <= (full & ~rel_mask) | set_mask;
        end
    end

    // Read FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state; a full partner bank at EOF keeps the stream going without a bubble.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    state_next = full[!rd_bank] ? STREAM : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read pointer; it only moves on an accepted beat so stalled outputs stay put.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else if (beat) begin
            if (last_beat) begin
                rd_idx  <= '0;
                rd_bank <= !rd_bank;
            end else begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
        end
    end

    // Stream outputs, driven straight from the bank being read.
    always_comb begin
        OUT_VALID = 1'b0;
        OUT_DATA  = '0;
        OUT_SOF   = 1'b0;
        OUT_EOF   = 1'b0;
        if (state == STREAM) begin
            OUT_VALID = 1'b1;
            OUT_DATA  = mem[{rd_bank, rd_idx}];
            OUT_SOF   = (rd_idx == '0);
            OUT_EOF   = (rd_idx == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_fir_fft_framer.sv
// tb_fir_fft_framer: scoreboard bench for fir_fft_framer.
// Instance A uses the default decimate-by-4 / 64-sample frame setup.
// Instance B runs without decimation and with short frames.
module tb_fir_fft_framer;

    localparam int DEC_A = 4;
    localparam int FL_A  = 64;
    localparam int DEC_B = 1;
    localparam int FL_B  = 8;

    logic clock, reset;

    logic               aValidIn, aReady, aValid, aSof, aEof, aSat;
    logic signed [31:0] aY;
    logic signed [15:0] aData;
    logic [15:0]        aDrop;

    logic               bValidIn, bReady, bValid, bSof, bEof, bSat;
    logic signed [31:0] bY;
    logic signed [15:0] bData;
    logic [15:0]        bDrop;

    int testsRun, failCount;
    int decA, decB, beatA, beatB;
    int sumExp, sumObs;
    bit stallA, stallB;
    logic signed [15:0] prevDataA, prevDataB;
    logic prevSofA, prevEofA, prevSofB, prevEofB;
    logic signed [15:0] qA[$];
    logic signed [15:0] qB[$];
    int satVals[8];

    fir_fft_framer #(.DEC_FACTOR(DEC_A), .FRAME_LEN(FL_A), .IN_W(32), .OUT_W(16)) dutA (
        .CLK(clock), .RST(reset), .IN_VALID(aValidIn), .Y_IN(aY),
        .OUT_DATA(aData), .OUT_VALID(aValid), .OUT_READY(aReady),
        .OUT_SOF(aSof), .OUT_EOF(aEof), .SAT_FLAG(aSat), .DROP_CNT(aDrop)
    );

    fir_fft_framer #(.DEC_FACTOR(DEC_B), .FRAME_LEN(FL_B), .IN_W(32), .OUT_W(16)) dutB (
        .CLK(clock), .RST(reset), .IN_VALID(bValidIn), .Y_IN(bY),
        .OUT_DATA(bData), .OUT_VALID(bValid), .OUT_READY(bReady),
        .OUT_SOF(bSof), .OUT_EOF(bEof), .SAT_FLAG(bSat), .DROP_CNT(bDrop)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic signed [15:0] sat16(input int v);
        if (v > 32767) return 16'sh7FFF;
        if (v < -32768) return 16'sh8000;
        return v[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle on instance A and push the expected output of any kept sample.
    task automatic applyStimulus(input bit valid, input int value, input bit expectDrop);
        aValidIn = valid;
        aY       = value;
        if (valid) begin
            if (decA == 0 && !expectDrop) begin
                qA.push_back(sat16(value));
                sumExp += int'(sat16(value));
            end
            decA = (decA == DEC_A - 1) ? 0 : decA + 1;
        end
        step();
    endtask

    task automatic applyStimulusB(input bit valid, input int value);
        bValidIn = valid;
        bY       = value;
        if (valid) begin
            if (decB == 0) qB.push_back(sat16(value));
            decB = (decB == DEC_B - 1) ? 0 : decB + 1;
        end
        step();
    endtask

    task automatic doReset();
        reset    = 1'b1;
        aValidIn = 1'b0;
        bValidIn = 1'b0;
        qA.delete();
        qB.delete();
        decA = 0;
        decB = 0;
        step();
        reset = 1'b0;
    endtask

    task automatic drainA(input int limit, input bit toggle);
        int n = 0;
        aValidIn = 1'b0;
        while (qA.size() != 0 && n < limit) begin
            aReady = toggle ? ~aReady : 1'b1;
            step();
            n++;
        end
        aReady = 1'b1;
        step();
        step();
        checkOutput("drainA", qA.size(), 0);
    endtask

    task automatic drainB(input int limit);
        int n = 0;
        bValidIn = 1'b0;
        while (qB.size() != 0 && n < limit) begin
            step();
            n++;
        end
        step();
        checkOutput("drainB", qB.size(), 0);
    endtask

    // Monitor A: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clock) begin
        if (reset) begin
            beatA  = 0;
            stallA = 1'b0;
        end else begin
            if (stallA) begin
                checkOutput("holdValidA", 32'(aValid), 1);
                if (aValid) begin
                    checkOutput("holdDataA", 32'(aData), 32'(prevDataA));
                    checkOutput("holdSofA", 32'(aSof), 32'(prevSofA));
                    checkOutput("holdEofA", 32'(aEof), 32'(prevEofA));
                end
            end
            if (aValid && aReady) begin
                testsRun++;
                assert (qA.size() != 0) else begin
                    failCount++;
                    $error("[TB] FAIL extraBeatA: observed data %0d expected no beat", aData);
                end
                if (qA.size() != 0) begin
                    logic signed [15:0] expData;
                    expData = qA.pop_front();
                    checkOutput("dataA", 32'(aData), 32'(expData));
                    checkOutput("sofA", 32'(aSof), (beatA == 0) ? 1 : 0);
                    checkOutput("eofA", 32'(aEof), (beatA == FL_A - 1) ? 1 : 0);
                    sumObs += int'(aData);
                end
                beatA  = (beatA + 1) % FL_A;
                stallA = 1'b0;
            end else if (aValid) begin
                stallA    = 1'b1;
                prevDataA = aData;
                prevSofA  = aSof;
                prevEofA  = aEof;
            end else begin
                stallA = 1'b0;
            end
        end
    end

    // Monitor B: same scoreboard discipline for the short-frame instance.
    always @(negedge clock) begin
        if (reset) begin
            beatB  = 0;
            stallB = 1'b0;
        end else begin
            if (stallB) begin
                checkOutput("holdValidB", 32'(bValid), 1);
                if (bValid) begin
                    checkOutput("holdDataB", 32'(bData), 32'(prevDataB));
                    checkOutput("holdSofB", 32'(bSof), 32'(prevSofB));
                    checkOutput("holdEofB", 32'(bEof), 32'(prevEofB));
                end
            end
            if (bValid && bReady) begin
                testsRun++;
                assert (qB.size() != 0) else begin
                    failCount++;
                    $error("[TB] FAIL extraBeatB: observed data %0d expected no beat", bData);
                end
                if (qB.size() != 0) begin
                    logic signed [15:0] expData;
                    expData = qB.pop_front();
                    checkOutput("dataB", 32'(bData), 32'(expData));
                    checkOutput("sofB", 32'(bSof), (beatB == 0) ? 1 : 0);
                    checkOutput("eofB", 32'(bEof), (beatB == FL_B - 1) ? 1 : 0);
                end
                beatB  = (beatB + 1) % FL_B;
                stallB = 1'b0;
            end else if (bValid) begin
                stallB    = 1'b1;
                prevDataB = bData;
                prevSofB  = bSof;
                prevEofB  = bEof;
            end else begin
                stallB = 1'b0;
            end
        end
    end

    // Directed sequence: ramp, saturation, overflow/drop, mid-stream reset, ready toggling, no decimation.
    initial begin
        testsRun  = 0;
        failCount = 0;
        decA = 0; decB = 0; sumExp = 0; sumObs = 0;
        reset = 1'b1;
        aValidIn = 1'b0; aY = '0; aReady = 1'b1;
        bValidIn = 1'b0; bY = '0; bReady = 1'b1;
        satVals = '{32767, -32768, 40000, -40000, 32768, -32769, 100, -100};
        repeat (3) step();
        reset = 1'b0;
        step();

        $display("[TB] reset state");
        checkOutput("rstValid", 32'(aValid), 0);
        checkOutput("rstData", 32'(aData), 0);
        checkOutput("rstSof", 32'(aSof), 0);
        checkOutput("rstEof", 32'(aEof), 0);
        checkOutput("rstSat", 32'(aSat), 0);
        checkOutput("rstDrop", 32'(aDrop), 0);

        $display("[TB] ramp with decimation by 4");
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1'b1, i, 1'b0);
            if (i == 252) checkOutput("latencyLow", 32'(aValid), 0);
            if (i == 253) begin
                checkOutput("latencyHigh", 32'(aValid), 1);
                checkOutput("firstSof", 32'(aSof), 1);
                checkOutput("firstData", 32'(aData), 0);
            end
        end
        drainA(200, 1'b0);

        $display("[TB] saturation");
        doReset();
        for (int k = 0; k < 64; k++) begin
            int v;
            v = (k < 8) ? satVals[k] : (int'($urandom_range(60000)) - 30000);
            applyStimulus(1'b1, v, 1'b0);
            for (int f = 0; f < 3; f++) applyStimulus(1'b1, 99999, 1'b0);
            if (k == 1) checkOutput("noClipAtLimits", 32'(aSat), 0);
            if (k == 2) checkOutput("clipSetsFlag", 32'(aSat), 1);
        end
        drainA(200, 1'b0);
        checkOutput("satSticky", 32'(aSat), 1);

        $display("[TB] both banks full with drops");
        doReset();
        checkOutput("satClearedByReset", 32'(aSat), 0);
        aReady = 1'b0;
        for (int i = 0; i < 532; i++) applyStimulus(1'b1, 1000 + i, i >= 512);
        checkOutput("dropCount", 32'(aDrop), 5);
        checkOutput("stallValid", 32'(aValid), 1);
        checkOutput("stallData", 32'(aData), 1000);
        aValidIn = 1'b0;
        aReady   = 1'b1;
        for (int i = 0; i < 2 * FL_A; i++) begin
            checkOutput("noGap", 32'(aValid), 1);
            step();
        end
        checkOutput("idleAfterPair", 32'(aValid), 0);

        $display("[TB] reset mid-stream");
        aReady = 1'b0;
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 5000 + i, 1'b0);
        aValidIn = 1'b0;
        aReady   = 1'b1;
        for (int i = 0; i < 30; i++) step();
        checkOutput("midFrameData", 32'(aData), 5120);
        checkOutput("dropBeforeReset", 32'(aDrop), 5);
        doReset();
        checkOutput("rstMidValid", 32'(aValid), 0);
        checkOutput("rstMidDrop", 32'(aDrop), 0);
        checkOutput("rstMidData", 32'(aData), 0);
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 7000 + i, 1'b0);
        drainA(200, 1'b0);

        $display("[TB] ready toggling");
        doReset();
        sumExp = 0;
        sumObs = 0;
        for (int i = 0; i < 512; i++) begin
            int v;
            v = int'($urandom_range(100000)) - 50000;
            if (i >= 256) aReady = (i % 2 == 0);
            applyStimulus(1'b1, v, 1'b0);
        end
        drainA(400, 1'b1);
        checkOutput("checksum", sumObs, sumExp);
        checkOutput("noDropsToggle", 32'(aDrop), 0);

        $display("[TB] no decimation, gapped input");
        bReady = 1'b1;
        for (int i = 0; i < 4 * FL_B; i++) applyStimulusB(i % 2 == 0, 200 + i);
        drainB(100);
        checkOutput("noDropsB", 32'(bDrop), 0);
        checkOutput("noSatB", 32'(bSat), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
